// File: rtl/mmio_gpio.sv
// Memory-mapped WIDTH-pin GPIO block in a 32-byte window at BASE_ADDR; other addresses pass through.
// Optional rising-edge interrupt logic (IRQ_EN, IRQ_STAT, irq) is built only when GPIO_IRQ_EN is defined.
module mmio_gpio #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FFE0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_mem,
  input  logic             read_mem,
  input  logic [31:0]      data_address,
  input  logic [31:0]      data_to_write,
  input  logic [31:0]      data_from_mem,
  output logic [31:0]      data_read,
  output logic             io_hit,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  typedef enum logic [2:0] {
    SEL_DIR,
    SEL_OUT,
    SEL_IN,
    SEL_IRQ_EN,
    SEL_IRQ_STAT,
    SEL_NONE
  } sel_t;

  sel_t             sel;
  logic             wr_hit;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      reg_rd;

  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] sync0_q, sync1_q;

  assign io_hit   = (data_address[31:5] == BASE_ADDR[31:5]);
  assign wr_hit   = io_hit & write_mem;
  assign wdata    = data_to_write[WIDTH-1:0];
  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;

  // Misaligned offsets and the unused tail of the window decode to SEL_NONE.
  always_comb begin
    sel = SEL_NONE;
    if (data_address[1:0] == 2'b00) begin
      case (data_address[4:2])
        3'd0:    sel = SEL_DIR;
        3'd1:    sel = SEL_OUT;
        3'd2:    sel = SEL_IN;
        3'd3:    sel = SEL_IRQ_EN;
        3'd4:    sel = SEL_IRQ_STAT;
        default: sel = SEL_NONE;
      endcase
    end
  end

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] irq_stat_q, irq_stat_d;
  logic [WIDTH-1:0] rise, clr;
  logic             irq_q, irq_d;

  // A rise in the same cycle as a W1C keeps the bit set.
  always_comb begin
    rise       = sync1_q & ~prev_q;
    clr        = (wr_hit && sel == SEL_IRQ_STAT) ? wdata : '0;
    irq_stat_d = (irq_stat_q & ~clr) | rise;
    irq_en_d   = irq_en_q;
    if (wr_hit && sel == SEL_IRQ_EN) irq_en_d = wdata;
    irq_d      = |(irq_stat_q & irq_en_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      prev_q     <= sync1_q;
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    dir_d = dir_q;
    out_d = out_q;
    if (wr_hit && sel == SEL_DIR) dir_d = wdata;
    if (wr_hit && sel == SEL_OUT) out_d = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q   <= '0;
      out_q   <= '0;
      sync0_q <= '0;
      sync1_q <= '0;
    end else begin
      dir_q   <= dir_d;
      out_q   <= out_d;
      sync0_q <= gpio_in;
      sync1_q <= sync0_q;
    end
  end

  always_comb begin
    reg_rd = '0;
    case (sel)
      SEL_DIR:      reg_rd[WIDTH-1:0] = dir_q;
      SEL_OUT:      reg_rd[WIDTH-1:0] = out_q;
      SEL_IN:       reg_rd[WIDTH-1:0] = sync1_q;
`ifdef GPIO_IRQ_EN
      SEL_IRQ_EN:   reg_rd[WIDTH-1:0] = irq_en_q;
      SEL_IRQ_STAT: reg_rd[WIDTH-1:0] = irq_stat_q;
`endif
      default:      reg_rd = '0;
    endcase
  end

  always_comb begin
    data_read = data_from_mem;
    if (io_hit) data_read = read_mem ? reg_rd : '0;
  end

endmodule

// File: tb/tb_mmio_gpio.sv
// Directed self-checking bench for mmio_gpio at WIDTH=8; IRQ expectations follow GPIO_IRQ_EN.
module tb_mmio_gpio;

  localparam logic [31:0] BASE = 32'hFFFF_FFE0;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_mem, read_mem;
  logic [31:0] data_address, data_to_write, data_from_mem;
  logic [31:0] data_read;
  logic        io_hit;
  logic [7:0]  gpio_in, gpio_out, gpio_oe;
  logic        irq;

  int checks = 0;
  int errors = 0;

  mmio_gpio #(.WIDTH(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .write_mem(write_mem), .read_mem(read_mem),
    .data_address(data_address), .data_to_write(data_to_write),
    .data_from_mem(data_from_mem), .data_read(data_read), .io_hit(io_hit),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    data_address  = addr;
    data_to_write = data;
    write_mem     = 1'b1;
    tick();
    write_mem     = 1'b0;
    data_to_write = '0;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    data_address = addr;
    read_mem     = 1'b1;
    #1;
    check(tag, data_read, exp);
    check({tag, "_hit"}, {31'd0, io_hit}, 32'd1);
    read_mem = 1'b0;
  endtask

  initial begin
    rst = 1'b1; write_mem = 1'b0; read_mem = 1'b0;
    data_address = BASE; data_to_write = '0; data_from_mem = '0; gpio_in = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_out", {24'd0, gpio_out}, 32'd0);
    check("rst_oe",  {24'd0, gpio_oe},  32'd0);
    check("rst_irq", {31'd0, irq},      32'd0);
    rd("rst_dir",  BASE + 32'h00, 32'd0);
    rd("rst_outr", BASE + 32'h04, 32'd0);
    rd("rst_in",   BASE + 32'h08, 32'd0);
    rd("rst_en",   BASE + 32'h0C, 32'd0);
    rd("rst_stat", BASE + 32'h10, 32'd0);

    // DIR/OUT writes, truncation to WIDTH, one edge of latency
    data_address = BASE + 32'h04; data_to_write = 32'hFFFF_FFA5; write_mem = 1'b1;
    #1 check("out_pre_edge", {24'd0, gpio_out}, 32'd0);
    tick(); write_mem = 1'b0;
    check("out_val", {24'd0, gpio_out}, 32'h0000_00A5);
    wr(BASE + 32'h00, 32'h0000_000F);
    check("oe_val", {24'd0, gpio_oe}, 32'h0000_000F);
    rd("rd_out", BASE + 32'h04, 32'h0000_00A5);
    rd("rd_dir", BASE + 32'h00, 32'h0000_000F);

    // Hit without read strobe returns 0
    data_address = BASE + 32'h04; data_from_mem = 32'h1234_5678;
    #1 check("hit_noread", data_read, 32'd0);

    // Read and write together: pre-write value on data_read
    data_address = BASE + 32'h04; data_to_write = 32'h0000_003C;
    write_mem = 1'b1; read_mem = 1'b1;
    #1 check("rw_prewrite", data_read, 32'h0000_00A5);
    tick(); write_mem = 1'b0; read_mem = 1'b0;
    check("rw_postwrite", {24'd0, gpio_out}, 32'h0000_003C);

    // Pass-through outside the window
    data_address = 32'h0000_1000; data_from_mem = 32'hDEAD_BEEF;
    data_to_write = 32'hFFFF_FFFF; write_mem = 1'b1; read_mem = 1'b1;
    #1 check("miss_hit", {31'd0, io_hit}, 32'd0);
    check("miss_data", data_read, 32'hDEAD_BEEF);
    tick(); write_mem = 1'b0; read_mem = 1'b0;
    check("miss_noread_data", data_read, 32'hDEAD_BEEF);
    check("miss_out_kept", {24'd0, gpio_out}, 32'h0000_003C);
    check("miss_oe_kept",  {24'd0, gpio_oe},  32'h0000_000F);

    // Ignored offsets: misaligned, unused tail, IN
    wr(BASE + 32'h05, 32'h0000_00FF);
    wr(BASE + 32'h01, 32'h0000_00FF);
    wr(BASE + 32'h14, 32'h0000_00FF);
    wr(BASE + 32'h08, 32'h0000_00FF);
    check("ign_out", {24'd0, gpio_out}, 32'h0000_003C);
    check("ign_oe",  {24'd0, gpio_oe},  32'h0000_000F);
    rd("ign_rd05", BASE + 32'h05, 32'd0);
    rd("ign_rd14", BASE + 32'h14, 32'd0);
    rd("ign_rd1c", BASE + 32'h1C, 32'd0);
    rd("ign_rdin", BASE + 32'h08, 32'd0);

`ifdef GPIO_IRQ_EN
    wr(BASE + 32'h0C, 32'h0000_0001);
    rd("en_rd", BASE + 32'h0C, 32'h0000_0001);
    gpio_in = 8'h01;                      // before edge E
    tick();                               // E
    rd("in_e0", BASE + 32'h08, 32'd0);
    tick();                               // E+1
    rd("in_e1", BASE + 32'h08, 32'h0000_0001);
    rd("stat_e1", BASE + 32'h10, 32'd0);
    tick();                               // E+2
    rd("stat_e2", BASE + 32'h10, 32'h0000_0001);
    check("irq_e2", {31'd0, irq}, 32'd0);
    tick();                               // E+3
    check("irq_e3", {31'd0, irq}, 32'd1);
    wr(BASE + 32'h10, 32'h0000_0001);
    rd("stat_clr", BASE + 32'h10, 32'd0);
    tick();
    check("irq_clr", {31'd0, irq}, 32'd0);

    // Rise coinciding with W1C: set wins
    gpio_in = 8'h00;
    repeat (3) tick();
    gpio_in = 8'h01;
    tick(); tick();                       // E, E+1
    wr(BASE + 32'h10, 32'h0000_0001);     // captured at E+2 with rise
    rd("stat_setwins", BASE + 32'h10, 32'h0000_0001);

    // Status sets even when disabled
    wr(BASE + 32'h0C, 32'h0000_0000);
    wr(BASE + 32'h10, 32'h0000_00FF);
    gpio_in = 8'h81;
    repeat (3) tick();
    rd("stat_noen", BASE + 32'h10, 32'h0000_0080);
    tick();
    check("irq_noen", {31'd0, irq}, 32'd0);

    // Asynchronous reset clears everything
    #2 rst = 1'b1;
    #1;
    check("arst_out", {24'd0, gpio_out}, 32'd0);
    check("arst_irq", {31'd0, irq},      32'd0);
    rd("arst_stat", BASE + 32'h10, 32'd0);
    rd("arst_in",   BASE + 32'h08, 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    rd("held_high_stat", BASE + 32'h10, 32'h0000_0081);
`else
    gpio_in = 8'h01;
    tick(); tick();
    rd("in_e1", BASE + 32'h08, 32'h0000_0001);
    wr(BASE + 32'h0C, 32'h0000_00FF);
    gpio_in = 8'h00;
    repeat (2) tick();
    gpio_in = 8'hFF;
    repeat (5) tick();
    check("noirq_irq", {31'd0, irq}, 32'd0);
    rd("noirq_en",   BASE + 32'h0C, 32'd0);
    rd("noirq_stat", BASE + 32'h10, 32'd0);
    wr(BASE + 32'h10, 32'h0000_00FF);
    rd("noirq_stat2", BASE + 32'h10, 32'd0);
    rd("noirq_in", BASE + 32'h08, 32'h0000_00FF);
    check("noirq_irq2", {31'd0, irq}, 32'd0);

    #2 rst = 1'b1;
    #1;
    check("arst_out", {24'd0, gpio_out}, 32'd0);
    check("arst_oe",  {24'd0, gpio_oe},  32'd0);
    rd("arst_in", BASE + 32'h08, 32'd0);
    tick();
    rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
